// File: rtl/dds_dac_pkg.sv
// Shared definitions for the DDS-to-DAC8411 output path: DAC word geometry,
// DAC power-down codes and the frame scheduler state encoding.
package dds_dac_pkg;

    localparam int          DAC_WIDTH    = 16;
    localparam logic [15:0] DAC_MIDSCALE = 16'h8000;

    // DAC8411 power-down bits carried in every frame
    localparam logic [1:0] PD_NORMAL   = 2'b00;
    localparam logic [1:0] PD_1K_GND   = 2'b01;
    localparam logic [1:0] PD_100K_GND = 2'b10;
    localparam logic [1:0] PD_HIGH_Z   = 2'b11;

    // Frame scheduler states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2
    } frame_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter. Push is ignored when full and pop
// is ignored when empty, so a simultaneous push and pop only both succeed
// when the FIFO held at least one entry and had room before the edge.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [LVL_W-1:0]      level_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // Storage array: data only, no reset needed since level gates every read
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Paces buffered DDS samples out to the DAC8411 SPI main: one frame per
// programmable sample period, using the main's load/csb handshake. Samples
// are optionally converted from two's complement to DAC offset binary, and
// underrun / missed-tick conditions are reported through sticky flags.
module dac_frame_scheduler
    import dds_dac_pkg::*;
#(
    parameter int DATA_WIDTH = DAC_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [DIV_WIDTH-1:0]         rate_div,
    input  logic                         signed_fmt,
    input  logic [1:0]                   power_state,
    input  logic                         clear_flags,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         spi_load,
    output logic [DATA_WIDTH-1:0]        spi_data,
    output logic [1:0]                   spi_power,
    input  logic                         spi_csb,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    output logic                         tick_missed
);

    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Two's complement to offset binary is a flip of the sign bit; when the
    // source is already offset binary the word passes through untouched.
    function automatic logic [DATA_WIDTH-1:0] to_dac_code(
        input logic [DATA_WIDTH-1:0] sample,
        input logic                  is_signed
    );
        logic signed [DATA_WIDTH-1:0] s_sample;
        s_sample = $signed(sample);
        return {s_sample[DATA_WIDTH-1] ^ is_signed, sample[DATA_WIDTH-2:0]};
    endfunction

    // ------------------------------------------------------------------
    // Sample buffer
    // ------------------------------------------------------------------
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sys_clk),
        .rst_i   (rst),
        .push_i  (fifo_push),
        .data_i  (s_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // ------------------------------------------------------------------
    // Sample-rate divider
    // ------------------------------------------------------------------
    logic [DIV_WIDTH-1:0] div_cnt_q;
    logic [DIV_WIDTH-1:0] div_cnt_d;
    logic                 tick;

    // Count down from rate_div; tick on zero and reload. A new rate_div is
    // only picked up at reload (or while disabled, when the count is parked).
    always_comb begin
        tick      = enable && (div_cnt_q == '0);
        div_cnt_d = div_cnt_q;
        if (!enable || tick) begin
            div_cnt_d = rate_div;
        end else begin
            div_cnt_d = div_cnt_q - DIV_WIDTH'(1);
        end
    end

    // Divider count register
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            div_cnt_q <= rate_div;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frame_state_e          state_q;
    logic                  spi_load_q;
    logic [DATA_WIDTH-1:0] spi_data_q;
    logic [1:0]            spi_power_q;
    logic [DATA_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] sample_word;
    logic                  frame_start;

    // A tick is only honoured while idle; an empty FIFO repeats the last
    // raw sample so the DAC output holds rather than jumping to midscale.
    assign frame_start = (state_q == ST_IDLE) && tick;
    assign fifo_pop    = frame_start && !fifo_empty;
    assign sample_word = fifo_empty ? last_q : fifo_head;

    // Frame sequencing with registered SPI-side outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            spi_load_q  <= 1'b0;
            spi_data_q  <= MIDSCALE;
            spi_power_q <= PD_NORMAL;
            last_q      <= MIDSCALE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) begin
                        spi_data_q  <= to_dac_code(sample_word, signed_fmt);
                        spi_power_q <= power_state;
                        spi_load_q  <= 1'b1;
                        last_q      <= sample_word;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Hold the request until the main acknowledges with csb low
                    if (!spi_csb) begin
                        spi_load_q <= 1'b0;
                        state_q    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (spi_csb) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    spi_load_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign spi_load  = spi_load_q;
    assign spi_data  = spi_data_q;
    assign spi_power = spi_power_q;

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic underrun_q;
    logic tick_missed_q;
    logic underrun_set;
    logic missed_set;

    assign underrun_set = frame_start && fifo_empty;
    assign missed_set   = tick && (state_q != ST_IDLE);

    // Flags latch on their event; a set in the same cycle beats a clear
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            underrun_q    <= 1'b0;
            tick_missed_q <= 1'b0;
        end else begin
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (clear_flags) begin
                underrun_q <= 1'b0;
            end
            if (missed_set) begin
                tick_missed_q <= 1'b1;
            end else if (clear_flags) begin
                tick_missed_q <= 1'b0;
            end
        end
    end

    assign underrun    = underrun_q;
    assign tick_missed = tick_missed_q;

endmodule
